// File: rtl/control_fsm_multi_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: FSM state
// type, opcode constants, datapath select encodings and ALU operation codes.
package control_fsm_multi_pkg;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic is_supported_op(input logic [6:0] op);
    return (op == OP_LOAD)  || (op == OP_STORE)  || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/control_fsm_multi_alu_dec.sv
// ALU decoder: maps the FSM's alu_op request plus instruction funct fields
// to an ALU operation code.
//   i_alu_op        00 add, 01 sub, 10 decode from funct fields
//   i_funct3        instr[14:12]
//   i_funct7b5      instr[30]
//   i_op5           instr[5] (distinguishes R-type from I-type)
//   o_alu_control   ALU operation
//   o_illegal_funct unsupported funct3 while funct decoding is requested
module alu_dec
  import control_fsm_multi_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op5,
  output logic [2:0] o_alu_control,
  output logic       o_illegal_funct
);

  always_comb begin
    o_alu_control   = ALU_ADD;
    o_illegal_funct = 1'b0;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // funct7b5 is an immediate bit for I-type, so sub only for R-type
          3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b100:  o_alu_control = ALU_XOR;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_illegal_funct = 1'b1;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_fsm_multi.sv
// Main control unit of the multi-cycle RV32I core. Steps each instruction
// through fetch/decode/execute/memory/writeback and drives the datapath.
//   clk, reset      core clock; asynchronous active-high reset
//   op/funct3/funct7b5/zero  instruction fields and ALU zero flag
//   mem_ready       shared memory completes the current request
//   mem_req/mem_write/adr_src  memory request handshake and address select
//   ir_write/pc_write/reg_write  architectural write enables
//   result_src/alu_src_a/alu_src_b/imm_src/alu_control  datapath selects
//   illegal_instr   one-cycle pulse on unsupported opcode or funct3
module control_fsm_multi
  import control_fsm_multi_pkg::*;
#(
  parameter int unsigned RESET_STATE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_instr
);

  state_t     r_state;
  logic [1:0] r_rst_cnt;
  logic [1:0] w_alu_op;
  logic       w_illegal_funct;

  alu_dec u_alu_dec (
    .i_alu_op        (w_alu_op),
    .i_funct3        (funct3),
    .i_funct7b5      (funct7b5),
    .i_op5           (op[5]),
    .o_alu_control   (alu_control),
    .o_illegal_funct (w_illegal_funct)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_RST;
      r_rst_cnt <= '0;
    end else begin
      case (r_state)
        S_RST: begin
          if (r_rst_cnt == 2'(RESET_STATE_CYCLES - 1)) r_state <= S_FETCH;
          else r_rst_cnt <= r_rst_cnt + 2'd1;
        end
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_RTYPE:          r_state <= S_EXECR;
            OP_ITYPE:          r_state <= S_EXECI;
            OP_BRANCH:         r_state <= S_BRANCH;
            OP_JAL:            r_state <= S_JAL;
            default:           r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
        S_EXECR,
        S_EXECI:    r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_BRANCH:   r_state <= S_FETCH;
        S_JAL:      r_state <= S_ALUWB;
        default:    r_state <= S_RST;
      endcase
    end
  end

  // Outputs decode the state register combinationally: handshake-qualified
  // enables act in the same cycle as mem_ready, and every output drops as
  // soon as the asynchronous reset forces RST.
  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    w_alu_op      = ALUOP_ADD;
    illegal_instr = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a     = SRCA_OLDPC;
        alu_src_b     = SRCB_IMM;
        illegal_instr = ~is_supported_op(op);
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a     = SRCA_RS1;
        alu_src_b     = SRCB_RS2;
        w_alu_op      = ALUOP_FUNCT;
        illegal_instr = w_illegal_funct;
      end
      S_EXECI: begin
        alu_src_a     = SRCA_RS1;
        alu_src_b     = SRCB_IMM;
        w_alu_op      = ALUOP_FUNCT;
        illegal_instr = w_illegal_funct;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        w_alu_op  = ALUOP_SUB;
        case (funct3)
          3'b000:  pc_write = zero;
          3'b001:  pc_write = ~zero;
          default: illegal_instr = 1'b1;
        endcase
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    imm_src = IMM_I;
    if (r_state != S_RST) begin
      case (op)
        OP_STORE:  imm_src = IMM_S;
        OP_BRANCH: imm_src = IMM_B;
        OP_JAL:    imm_src = IMM_J;
        default:   imm_src = IMM_I;
      endcase
    end
  end

endmodule
